// File: rtl/hi_lo_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: opcodes, FSM states and read selects.
package hi_lo_muldiv_pkg;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_MULT    = 3'd1;
    localparam logic [2:0] OP_MULTU   = 3'd2;
    localparam logic [2:0] OP_DIV     = 3'd3;
    localparam logic [2:0] OP_DIVU    = 3'd4;
    localparam logic [2:0] OP_MTHI    = 3'd5;
    localparam logic [2:0] OP_MTLO    = 3'd6;
    localparam logic [2:0] OP_MADDSUB = 3'd7;

    // OP_MADDSUB flags carried in op_b: bit 0 set = accumulate (add), clear = subtract;
    // bit 1 set = signed product.
    localparam int MADD_ADD_BIT    = 0;
    localparam int MADD_SIGNED_BIT = 1;

    localparam logic READ_LO = 1'b0;
    localparam logic READ_HI = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/hi_lo_muldiv_div_serial.sv
// Radix-2 restoring unsigned divider: one quotient bit per cycle, WIDTH cycles after start.
import hi_lo_muldiv_pkg::*;

module muldiv_div_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] count_q;
    logic             running_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        done    = running_q && (count_q == '0);
    end

    // The dividend shifts out of quo_q as quotient bits shift in behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            running_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
        end else if (start) begin
            count_q   <= CNT_W'(WIDTH);
            running_q <= 1'b1;
            quo_q     <= dividend;
            rem_q     <= '0;
            dvs_q     <= divisor;
        end else if (done) begin
            running_q <= 1'b0;
        end else if (running_q) begin
            count_q <= count_q - CNT_W'(1);
            if (!diff[WIDTH]) begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= shifted[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/hi_lo_muldiv.sv
// HI/LO register pair with multicycle multiply and serial divide for the MIPS execute stage.
// Define HI_LO_MULDIV_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate opcode.
import hi_lo_muldiv_pkg::*;

module hi_lo_muldiv #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             op_accept,
    output logic             busy,
    input  logic             read_sel,
    output logic [WIDTH-1:0] read_data,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q, a_q, b_q;
    logic               mul_signed_q, quo_neg_q, rem_neg_q, div_zero_q;
    logic               is_mul_op, is_div_op, div_signed;
    logic               div_start, div_done, mul_commit, div_commit;
    logic [WIDTH-1:0]   div_dividend, div_divisor, div_quo, div_rem;
    logic [2*WIDTH-1:0] ext_a, ext_b, product, mul_result;
`ifdef HI_LO_MULDIV_MADD_EN
    logic               madd_q, madd_add_q;
`endif

    always_comb begin
`ifdef HI_LO_MULDIV_MADD_EN
        is_mul_op = (op_code == OP_MULT) || (op_code == OP_MULTU) || (op_code == OP_MADDSUB);
`else
        is_mul_op = (op_code == OP_MULT) || (op_code == OP_MULTU);
`endif
        is_div_op    = (op_code == OP_DIV) || (op_code == OP_DIVU);
        div_signed   = (op_code == OP_DIV);
        div_dividend = (div_signed && op_a[WIDTH-1]) ? -op_a : op_a;
        div_divisor  = (div_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    end

    // Sign-extending to 2*WIDTH makes one unsigned multiply serve both signednesses.
    always_comb begin
        ext_a   = mul_signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        ext_b   = mul_signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        product = ext_a * ext_b;
`ifdef HI_LO_MULDIV_MADD_EN
        if (madd_q) begin
            mul_result = madd_add_q ? ({hi_q, lo_q} + product) : ({hi_q, lo_q} - product);
        end else begin
            mul_result = product;
        end
`else
        mul_result = product;
`endif
    end

    always_comb begin
        state_d    = state_q;
        busy       = (state_q != IDLE);
        op_accept  = op_valid && !busy;
        div_start  = 1'b0;
        mul_commit = 1'b0;
        div_commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_accept && is_mul_op) begin
                    state_d = MUL;
                end else if (op_accept && is_div_op) begin
                    state_d   = DIV;
                    div_start = 1'b1;
                end
            end
            MUL: begin
                if (cnt_q == '0) begin
                    mul_commit = 1'b1;
                    state_d    = IDLE;
                end
            end
            DIV: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (div_done) begin
                    div_commit = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            mul_signed_q <= 1'b0;
            quo_neg_q    <= 1'b0;
            rem_neg_q    <= 1'b0;
            div_zero_q   <= 1'b0;
`ifdef HI_LO_MULDIV_MADD_EN
            madd_q       <= 1'b0;
            madd_add_q   <= 1'b0;
`endif
        end else if (state_q == IDLE && op_accept) begin
            if (op_code == OP_MTHI) hi_q <= op_a;
            if (op_code == OP_MTLO) lo_q <= op_a;
            a_q          <= op_a;
            b_q          <= op_b;
            cnt_q        <= is_div_op ? CNT_W'(WIDTH - 1) : CNT_W'(MUL_LAT - 1);
            quo_neg_q    <= div_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            rem_neg_q    <= div_signed && op_a[WIDTH-1];
            div_zero_q   <= (op_b == '0);
`ifdef HI_LO_MULDIV_MADD_EN
            mul_signed_q <= (op_code == OP_MULT) ||
                            ((op_code == OP_MADDSUB) && op_b[MADD_SIGNED_BIT]);
            madd_q       <= (op_code == OP_MADDSUB);
            madd_add_q   <= op_b[MADD_ADD_BIT];
`else
            mul_signed_q <= (op_code == OP_MULT);
`endif
        end else if (mul_commit) begin
            {hi_q, lo_q} <= mul_result;
        end else if (div_commit) begin
            // Divide-by-zero reports all-ones quotient and the raw dividend.
            if (div_zero_q) begin
                lo_q <= '1;
                hi_q <= a_q;
            end else begin
                lo_q <= quo_neg_q ? -div_quo : div_quo;
                hi_q <= rem_neg_q ? -div_rem : div_rem;
            end
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    muldiv_div_serial #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    assign read_data = (read_sel == READ_HI) ? hi_q : lo_q;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

endmodule

// File: tb/tb_hi_lo_muldiv.sv
// Self-checking bench for hi_lo_muldiv: directed vector table, corner sequences, random ops vs. model.
import hi_lo_muldiv_pkg::*;

module tb_hi_lo_muldiv;

    localparam int W       = 32;
    localparam int LAT_MUL = 4;
    localparam int LAT_DIV = W + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          op_valid = 1'b0;
    logic [2:0]    op_code = OP_NOP;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          op_accept;
    logic          busy;
    logic          read_sel = READ_LO;
    logic [W-1:0]  read_data;
    logic [W-1:0]  hi_out;
    logic [W-1:0]  lo_out;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    hi_lo_muldiv #(
        .WIDTH  (W),
        .MUL_LAT(LAT_MUL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op_code  (op_code),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_accept(op_accept),
        .busy     (busy),
        .read_sel (read_sel),
        .read_data(read_data),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
    } vec_t;

    vec_t vecs[11];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Architectural reference: plain integer arithmetic on 64-bit values.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] hi_i, input logic [W-1:0] lo_i,
                                  output logic [W-1:0] hi_o, output logic [W-1:0] lo_o);
        longint sa, sb, sq, sr;
        logic [63:0] ua, ub, p, acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        hi_o = hi_i;
        lo_o = lo_i;
        case (op)
            OP_MULT:  begin p = sa * sb; {hi_o, lo_o} = p; end
            OP_MULTU: begin p = ua * ub; {hi_o, lo_o} = p; end
            OP_DIV, OP_DIVU: begin
                if (b == 0) begin
                    lo_o = '1;
                    hi_o = a;
                end else if (op == OP_DIV) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    lo_o = sq[31:0];
                    hi_o = sr[31:0];
                end else begin
                    p = ua / ub;
                    acc = ua % ub;
                    lo_o = p[31:0];
                    hi_o = acc[31:0];
                end
            end
            OP_MTHI: hi_o = a;
            OP_MTLO: lo_o = a;
`ifdef HI_LO_MULDIV_MADD_EN
            OP_MADDSUB: begin
                if (b[1]) p = sa * sb;
                else      p = ua * ub;
                acc = {hi_i, lo_i};
                acc = b[0] ? acc + p : acc - p;
                {hi_o, lo_o} = acc;
            end
`endif
            default: ;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op);
        case (op)
            OP_MULT, OP_MULTU: return LAT_MUL;
            OP_DIV, OP_DIVU:   return LAT_DIV;
`ifdef HI_LO_MULDIV_MADD_EN
            OP_MADDSUB:        return LAT_MUL;
`endif
            default:           return 0;
        endcase
    endfunction

    // Issue one op in an idle cycle and count how many cycles busy stays high afterwards.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic accepted, output int lat);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = op;
        op_a     = a;
        op_b     = b;
        #1 accepted = op_accept;
        @(posedge clk);
        #1 op_valid = 1'b0;
        lat = 0;
        while (busy && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic checkRegs(input string tag, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        checkOutput({tag, " hi_out"}, hi_out, ehi);
        checkOutput({tag, " lo_out"}, lo_out, elo);
        read_sel = READ_HI;
        #1 checkOutput({tag, " read HI"}, read_data, ehi);
        read_sel = READ_LO;
        #1 checkOutput({tag, " read LO"}, read_data, elo);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       acc;
        int         lat;
        int         n;
        logic [2:0] ops[7];
        logic [2:0] op;
        logic [W-1:0] a, b, nhi, nlo;

        vecs[0]  = '{OP_MTHI,  32'h1234_5678, 32'h0,         32'h1234_5678, 32'h0000_0000, 0};
        vecs[1]  = '{OP_MTLO,  32'h9ABC_DEF0, 32'h0,         32'h1234_5678, 32'h9ABC_DEF0, 0};
        vecs[2]  = '{OP_MULT,  32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_MUL};
        vecs[3]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'hFFFF_FFFE, LAT_MUL};
        vecs[4]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_DIV};
        vecs[5]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        LAT_DIV};
        vecs[6]  = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, LAT_DIV};
        vecs[7]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, LAT_DIV};
        vecs[8]  = '{OP_NOP,   32'hDEAD_BEEF, 32'h1,         32'h0,         32'h8000_0000, 0};
        vecs[9]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, LAT_DIV};
        vecs[10] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, LAT_DIV};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("reset busy", busy, 0);
        checkRegs("reset", '0, '0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, acc, lat);
            checkOutput($sformatf("vec%0d accept", i), acc, 1);
            checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            checkRegs($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
        end
        m_hi = vecs[10].hi;
        m_lo = vecs[10].lo;

        // MTLO presented while a divide is running must be refused and leave LO alone.
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_DIVU; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk);
        #1 op_code = OP_MTLO; op_a = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("busy mtlo accept %0d", i), op_accept, 0);
            checkOutput($sformatf("busy mtlo lo %0d", i), lo_out, m_lo);
        end
        op_valid = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        checkOutput("busy mtlo drained", busy, 0);
        checkRegs("div after mtlo", 32'd2, 32'd14);

        // A request held through a multiply is taken once busy drops.
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_MULT; op_a = 32'd3; op_b = 32'd5;
        @(posedge clk);
        #1 op_code = OP_MTHI; op_a = 32'hAAAA_5555;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        checkOutput("held mul latency", n, LAT_MUL);
        checkOutput("held mul accept", op_accept, 1);
        @(posedge clk);
        #1 op_valid = 1'b0;
        checkOutput("held mthi busy", busy, 0);
        checkRegs("held mthi", 32'hAAAA_5555, 32'd15);

        // Reset part-way through a divide aborts it without a late write.
        applyStimulus(OP_MTLO, 32'h0000_0022, 32'h0, acc, lat);
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_DIV; op_a = 32'd1000; op_b = 32'd3;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("abort busy", busy, 0);
        checkRegs("abort", '0, '0);
        repeat (40) @(posedge clk);
        #1 checkOutput("abort busy later", busy, 0);
        checkRegs("abort later", '0, '0);
        m_hi = '0;
        m_lo = '0;

        // Accumulate opcode: active only when the feature macro is defined.
        applyStimulus(OP_MTLO, 32'hFFFF_FFFF, 32'h0, acc, lat);
        applyStimulus(OP_MADDSUB, 32'd1, 32'd1, acc, lat);
`ifdef HI_LO_MULDIV_MADD_EN
        checkOutput("maddu latency", lat, LAT_MUL);
        checkRegs("maddu", 32'd1, 32'd0);
`else
        checkOutput("maddu latency", lat, 0);
        checkRegs("maddu", 32'd0, 32'hFFFF_FFFF);
`endif
        model(OP_MADDSUB, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, m_hi, m_lo);

        ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MADDSUB};
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 6)];
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = '1; end
            model(op, a, b, m_hi, m_lo, nhi, nlo);
            m_hi = nhi;
            m_lo = nlo;
            applyStimulus(op, a, b, acc, lat);
            checkOutput($sformatf("rand%0d latency op%0d", i, op), lat, model_lat(op));
            checkOutput($sformatf("rand%0d hi op%0d a=%h b=%h", i, op, a, b), hi_out, m_hi);
            checkOutput($sformatf("rand%0d lo op%0d a=%h b=%h", i, op, a, b), lo_out, m_lo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hi_lo_muldiv.md
Name: hi_lo_muldiv

Overview:
Parametrised HI/LO register pair with an integrated multicycle multiply/divide engine for the MIPS core. It executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds the {HI,LO} result. It exposes a busy flag so the pipeline stalls MFHI/MFLO and further mul/div ops until the result is committed. It sits beside the main register file in the execute stage.

Parameters:
WIDTH, 32, data width of operands and of each of HI and LO
MUL_LAT, 4, cycles from multiply acceptance to HI/LO update (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
op_valid  input  1  operation request this cycle
op_code  input  3  operation select (encodings in package)
op_a  input  WIDTH  rs operand / dividend / MTHI-MTLO data
op_b  input  WIDTH  rt operand / divisor
op_accept  output  1  op_valid && !busy (combinational)
busy  output  1  multiply/divide in flight
read_sel  input  1  0 = LO, 1 = HI
read_data  output  WIDTH  combinational read of the selected register
hi_out  output  WIDTH  HI register, direct
lo_out  output  WIDTH  LO register, direct

Behaviour:
- Reset: HI=0, LO=0, busy=0, FSM=IDLE. Reset mid-operation aborts it with no HI/LO write.
- FSM states are IDLE, MUL, DIV, DONE.
- Acceptance: an op is accepted only when op_valid=1 and busy=0. An op_valid while busy is ignored, with no queueing. The core must hold the request.
- MTHI/MTLO: HI (resp. LO) <= op_a at the accepting edge. Single cycle; busy stays 0.
- MULT/MULTU: capture operands and go to MUL. busy=1 from the next cycle. After MUL_LAT cycles, {HI,LO} <= 2*WIDTH-bit product (signed or unsigned). busy falls in the same cycle HI/LO update.
- DIV/DIVU: radix-2 restoring, one quotient bit per cycle. WIDTH cycles in DIV, then 1 cycle in DONE for sign fix-up and write. Total WIDTH+1 cycles busy.
  - Results: LO = quotient (truncated toward zero), HI = remainder (sign of dividend).
  - Divide-by-zero: LO = all ones, HI = op_a, same latency.
  - Signed MIN / -1: LO = MIN, HI = 0.
- Reads: read_data, hi_out and lo_out always show committed values. Old values are visible while busy; there is no forwarding of in-flight results.
- Accept on the busy-falling edge: allowed. The new op is accepted the same cycle HI/LO update, and busy reasserts next cycle.
- Unused op_code values: accepted, no effect.

Optional Feature:
Macro HI_LO_MULDIV_MADD_EN.
- Defined: opcodes MADD, MADDU, MSUB and MSUBU are enabled. They compute {HI,LO} <= {HI,LO} ± product, modulo 2^(2*WIDTH), with the same MUL_LAT latency.
- Not defined: these encodings behave as unused opcodes (no-op).

Decomposition:
- Package hi_lo_muldiv_pkg holds:
  - op_code encodings: OP_NOP=0, OP_MULT=1, OP_MULTU=2, OP_DIV=3, OP_DIVU=4, OP_MTHI=5, OP_MTLO=6, OP_MADDSUB=7
  - op_b[0] selects add/sub and op_b[1] selects signedness when OP_MADDSUB is enabled
  - FSM state enum
  - READ_LO/READ_HI constants
- Sub-module muldiv_div_serial: iterative unsigned divider core with start, done, quotient and remainder. The top level handles sign and special cases.

Test Plan:
- Reset then MTHI 0x1234_5678 then MTLO 0x9ABC_DEF0: next cycle read_sel=1 gives 0x12345678 and read_sel=0 gives 0x9ABCDEF0; busy is never 1.
- MULT op_a=0xFFFF_FFFF (-1), op_b=2, MUL_LAT=4: busy=1 for 4 cycles, then HI=0xFFFF_FFFF and LO=0xFFFF_FFFE. MULTU with the same operands gives HI=1, LO=0xFFFF_FFFE.
- DIV -7 / 2: after 33 cycles LO=0xFFFF_FFFD (-3) and HI=0xFFFF_FFFF (-1). DIVU 100/7 gives LO=14, HI=2.
- Special cases:
  - DIVU 5/0 gives LO=0xFFFF_FFFF, HI=5.
  - DIV 0x8000_0000 / -1 gives LO=0x8000_0000, HI=0.
- Interaction cases:
  - MTLO issued while a DIV is busy: op_accept=0 and LO is unchanged until the DIV commits.
  - Reset asserted at divide cycle 10: busy=0, HI=LO=0 next cycle.
- With HI_LO_MULDIV_MADD_EN defined: preload HI=0, LO=0xFFFF_FFFF, then MADDU 1*1 gives HI=1, LO=0. Without the macro, the same op leaves HI/LO unchanged.
